// File: rtl/checkpoint_seq_monitor.sv
// Ordered checkpoint sequencer: a watched field must show each programmed value in turn,
// held for STABLE cycles, within a per-stage timeout. Reports pass/fail, stage and cause.
module checkpoint_seq_monitor #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int TMO_W  = 18,
    parameter int STABLE = 2,
    parameter int STRICT = 0
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]         cfg_data,
    input  logic [$clog2(DEPTH):0]   cfg_count,
    input  logic [TMO_W-1:0]         tmo_limit,
    input  logic                     start,
    input  logic [WIDTH-1:0]         watch,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               fail_code,
    output logic [$clog2(DEPTH):0]   stage,
    output logic                     match_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STABLE + 1) + 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] STAB_N  = SW'(STABLE);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;
    state_t r_state, w_state_nxt;

    logic [WIDTH-1:0] r_ram [DEPTH];
    logic [WIDTH-1:0] r_watch_q, r_last_q, r_run_val;
    logic [AW:0]      r_count, r_stage;
    logic [TMO_W-1:0] r_tmo_limit, r_tmo_cnt;
    logic [SW-1:0]    r_stab_cnt, r_run_cnt;
    logic             r_pass, r_fail, r_match;
    logic [1:0]       r_fail_code;

    logic             w_armed, w_start, w_empty, w_hit, w_match, w_last, w_tmo, w_viol, w_same;
    logic [WIDTH-1:0] w_exp;
    logic [SW-1:0]    w_stab_inc, w_run_nxt;
    logic [TMO_W-1:0] w_tmo_inc;
    logic [AW:0]      w_count_sat, w_stage_inc;

    assign w_armed     = (r_state == S_ARMED);
    assign w_start     = start && !w_armed;
    assign w_empty     = (r_count == '0);
    assign w_exp       = r_ram[r_stage[AW-1:0]];
    assign w_hit       = (r_watch_q == w_exp);
    assign w_stab_inc  = r_stab_cnt + 1'b1;
    assign w_match     = w_armed && !w_empty && w_hit && (w_stab_inc >= STAB_N);
    assign w_stage_inc = r_stage + 1'b1;
    assign w_last      = (w_stage_inc == r_count);
    assign w_count_sat = (cfg_count > CNT_MAX) ? CNT_MAX : cfg_count;

    // Saturating so a long run can never wrap back under the limit.
    assign w_tmo_inc = (&r_tmo_cnt) ? r_tmo_cnt : r_tmo_cnt + 1'b1;
    assign w_tmo     = w_armed && (r_tmo_limit != '0) && (w_tmo_inc >= r_tmo_limit);

    // Length of the current run of an unchanged watch_q, for strict-order checking.
    assign w_same    = (r_watch_q == r_run_val);
    assign w_run_nxt = !w_same ? SW'(1) :
                       (r_run_cnt >= STAB_N) ? r_run_cnt : r_run_cnt + 1'b1;
    assign w_viol    = (STRICT != 0) && w_armed && (w_run_nxt >= STAB_N) &&
                       !w_hit && (r_watch_q != r_last_q);

    always_ff @(posedge clock) begin
        if (!resetb) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_ARMED: begin
                if (w_empty)               w_state_nxt = S_PASS;
                else if (w_match) begin
                    if (w_last)            w_state_nxt = S_PASS;
                end
                else if (w_tmo || w_viol)  w_state_nxt = S_FAIL;
            end
            default: if (start)            w_state_nxt = S_ARMED;
        endcase
    end

    // Checkpoint storage is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (cfg_we && !w_armed) r_ram[cfg_addr] <= cfg_data;
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_watch_q   <= '0;
            r_last_q    <= '0;
            r_run_val   <= '0;
            r_run_cnt   <= '0;
            r_count     <= '0;
            r_stage     <= '0;
            r_tmo_limit <= '0;
            r_tmo_cnt   <= '0;
            r_stab_cnt  <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= 2'b00;
            r_match     <= 1'b0;
        end else begin
            r_watch_q <= watch;
            r_match   <= 1'b0;
            if (w_start) begin
                r_count     <= w_count_sat;
                r_tmo_limit <= tmo_limit;
                r_pass      <= 1'b0;
                r_fail      <= 1'b0;
                r_fail_code <= 2'b00;
                r_stage     <= '0;
                r_stab_cnt  <= '0;
                r_tmo_cnt   <= '0;
                r_run_cnt   <= '0;
                r_run_val   <= watch;
                r_last_q    <= watch;
            end else if (w_armed) begin
                r_run_cnt <= w_run_nxt;
                r_run_val <= r_watch_q;
                if (w_empty) begin
                    r_pass <= 1'b1;
                end else if (w_match) begin
                    r_match    <= 1'b1;
                    r_last_q   <= w_exp;
                    r_stage    <= w_stage_inc;
                    r_stab_cnt <= '0;
                    r_tmo_cnt  <= '0;
                    if (w_last) r_pass <= 1'b1;
                end else begin
                    r_stab_cnt <= w_hit ? w_stab_inc : '0;
                    r_tmo_cnt  <= w_tmo_inc;
                    if (w_tmo) begin
                        r_fail      <= 1'b1;
                        r_fail_code <= 2'b01;
                    end else if (w_viol) begin
                        r_fail      <= 1'b1;
                        r_fail_code <= 2'b10;
                    end
                end
            end
        end
    end

    assign busy        = w_armed;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign fail_code   = r_fail_code;
    assign stage       = r_stage;
    assign match_pulse = r_match;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed bench: one non-strict and one strict instance share all stimulus.
module tb_checkpoint_seq_monitor;
    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic [3:0]  cfg_count = '0;
    logic [17:0] tmo_limit = '0;
    logic        start = 1'b0;
    logic [15:0] watch = '0;

    logic       busy0, pass0, fail0, mp0, busy1, pass1, fail1, mp1;
    logic [1:0] fc0, fc1;
    logic [3:0] stage0, stage1;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] seq [8] = '{16'hAB40, 16'hAB41, 16'hAB51, 16'hAB60,
                             16'hAB61, 16'hAB62, 16'hAB63, 16'hAB64};

    checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(8), .TMO_W(18), .STABLE(2), .STRICT(0)) u_dut0 (
        .clock(clock), .resetb(resetb), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_count(cfg_count), .tmo_limit(tmo_limit),
        .start(start), .watch(watch), .busy(busy0), .pass(pass0), .fail(fail0),
        .fail_code(fc0), .stage(stage0), .match_pulse(mp0));

    checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(8), .TMO_W(18), .STABLE(2), .STRICT(1)) u_dut1 (
        .clock(clock), .resetb(resetb), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_count(cfg_count), .tmo_limit(tmo_limit),
        .start(start), .watch(watch), .busy(busy1), .pass(pass1), .fail(fail1),
        .fail_code(fc1), .stage(stage1), .match_pulse(mp1));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] cnt, input logic [17:0] tmo);
        watch     = 16'h0000;
        cfg_count = cnt;
        tmo_limit = tmo;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Value held 5 cycles; pulse expected exactly 2 edges after watch_q takes it.
    task automatic match_step(input logic [15:0] val, input int exp_stage);
        watch = val;
        tick();
        tick();
        chk("early_pulse0", 32'(mp0), 0);
        chk("early_pulse1", 32'(mp1), 0);
        tick();
        chk("pulse0", 32'(mp0), 1);
        chk("pulse1", 32'(mp1), 1);
        chk("stage0", 32'(stage0), 32'(exp_stage));
        chk("stage1", 32'(stage1), 32'(exp_stage));
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out0", 32'({busy0, pass0, fail0, fc0, stage0, mp0}), 0);
        chk("rst_out1", 32'({busy1, pass1, fail1, fc1, stage1, mp1}), 0);
        resetb = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'(i);
            cfg_data = seq[i];
            tick();
        end
        cfg_we = 1'b0;

        // Basic pass
        do_start(4'd3, 18'd1000);
        chk("start_busy0", 32'(busy0), 1);
        chk("start_stage0", 32'(stage0), 0);
        for (int i = 0; i < 3; i++) match_step(seq[i], i + 1);
        chk("pass_flags0", 32'({pass0, busy0, fail0}), 32'b100);
        chk("pass_flags1", 32'({pass1, busy1, fail1}), 32'b100);
        chk("pass_stage0", 32'(stage0), 3);

        // Timeout straight from start
        do_start(4'd3, 18'd5);
        chk("restart_pass0", 32'({pass0, busy0}), 32'b01);
        repeat (4) tick();
        chk("tmo5_early0", 32'(fail0), 0);
        tick();
        chk("tmo5_fail0", 32'({fail0, fc0, stage0}), 32'({1'b1, 2'b01, 4'd0}));
        chk("tmo5_fail1", 32'({fail1, fc1, stage1}), 32'({1'b1, 2'b01, 4'd0}));

        // Timeout after first match
        do_start(4'd3, 18'd1000);
        watch = 16'hAB40;
        tick();
        tick();
        tick();
        chk("tmo_match0", 32'(mp0), 1);
        watch = 16'h0000;
        repeat (999) tick();
        chk("tmo_early0", 32'({fail0, busy0}), 32'b01);
        chk("tmo_strict1", 32'({fail1, fc1, stage1}), 32'({1'b1, 2'b10, 4'd1}));
        tick();
        chk("tmo_fail0", 32'({fail0, fc0, stage0, busy0}), 32'({1'b1, 2'b01, 4'd1, 1'b0}));

        // Strict order violation vs. non-strict timeout
        do_start(4'd3, 18'd20);
        watch = 16'hAB40;
        tick();
        tick();
        tick();
        chk("strict_match1", 32'(mp1), 1);
        watch = 16'hAB51;
        tick();
        tick();
        chk("strict_early1", 32'(fail1), 0);
        tick();
        chk("strict_fail1", 32'({fail1, fc1, stage1}), 32'({1'b1, 2'b10, 4'd1}));
        chk("strict_nofail0", 32'({fail0, busy0}), 32'b01);
        repeat (16) tick();
        chk("nonstrict_early0", 32'(fail0), 0);
        tick();
        chk("nonstrict_tmo0", 32'({fail0, fc0, stage0}), 32'({1'b1, 2'b01, 4'd1}));

        // Debounce: one-cycle glitch ignored, two-cycle hold matches
        do_start(4'd3, 18'd1000);
        watch = 16'hAB40;
        tick();
        watch = 16'h0000;
        tick();
        tick();
        chk("glitch_pulse0", 32'(mp0), 0);
        chk("glitch_stage0", 32'(stage0), 0);
        chk("glitch_stage1", 32'({stage1, fail1}), 0);
        tick();
        watch = 16'hAB40;
        tick();
        tick();
        watch = 16'hAB41;
        tick();
        chk("hold2_pulse0", 32'(mp0), 1);
        chk("hold2_stage1", 32'(stage1), 1);
        tick();
        tick();
        chk("hold2_next0", 32'({mp0, stage0}), 32'({1'b1, 4'd2}));
        match_step(16'hAB51, 3);
        chk("deb_pass1", 32'({pass1, fail1}), 32'b10);

        // Timeout disabled with tmo_limit = 0
        do_start(4'd3, 18'd0);
        repeat (300) tick();
        chk("tmo0_busy0", 32'({busy0, fail0}), 32'b10);
        chk("tmo0_busy1", 32'({busy1, fail1}), 32'b10);
        for (int i = 0; i < 3; i++) match_step(seq[i], i + 1);

        // Config and start ignored while busy
        do_start(4'd3, 18'd1000);
        cfg_we    = 1'b1;
        cfg_addr  = 3'd1;
        cfg_data  = 16'hDEAD;
        cfg_count = 4'd0;
        start     = 1'b1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        chk("lock_busy0", 32'({busy0, stage0}), 32'({1'b1, 4'd0}));
        for (int i = 0; i < 3; i++) match_step(seq[i], i + 1);
        chk("lock_pass0", 32'({pass0, fail0, stage0}), 32'({2'b10, 4'd3}));

        // count = 0 passes one edge after start
        do_start(4'd0, 18'd1000);
        chk("cnt0_armed0", 32'({busy0, pass0}), 32'b10);
        tick();
        chk("cnt0_pass0", 32'({busy0, pass0, fail0, stage0}), 32'({3'b010, 4'd0}));
        chk("cnt0_pass1", 32'({busy1, pass1, fail1, stage1}), 32'({3'b010, 4'd0}));

        // count above DEPTH saturates to DEPTH
        do_start(4'd15, 18'd1000);
        for (int i = 0; i < 8; i++) match_step(seq[i], i + 1);
        chk("sat_pass0", 32'({pass0, busy0, stage0}), 32'({2'b10, 4'd8}));
        chk("sat_pass1", 32'({pass1, busy1, stage1}), 32'({2'b10, 4'd8}));

        // Reset after the second match, then a full rerun
        do_start(4'd3, 18'd1000);
        match_step(seq[0], 1);
        match_step(seq[1], 2);
        resetb = 1'b0;
        tick();
        chk("midrst_out0", 32'({busy0, pass0, fail0, fc0, stage0, mp0}), 0);
        chk("midrst_out1", 32'({busy1, pass1, fail1, fc1, stage1, mp1}), 0);
        resetb = 1'b1;
        tick();
        do_start(4'd3, 18'd1000);
        chk("rerun_busy0", 32'(busy0), 1);
        for (int i = 0; i < 3; i++) match_step(seq[i], i + 1);
        chk("rerun_pass0", 32'({pass0, fail0, stage0}), 32'({2'b10, 4'd3}));
        chk("rerun_pass1", 32'({pass1, fail1, stage1}), 32'({2'b10, 4'd3}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/checkpoint_seq_monitor.md
# checkpoint_seq_monitor

Parametrised on-chip checkpoint sequencer for DV-style self-checking.
- Watches a `WIDTH`-bit field driven by firmware, typically `mprj_io[31:16]` as the checkbits.
- Requires a programmed ordered list of up to `DEPTH` checkpoint values to appear in order, each held stable, within a per-stage timeout.
- Reports pass/fail, the failing stage and a failure code.
- Sits in the user project area as a generalisation of single-value `wait()` checkpoint sequences: programmable depth, width, timeout, debounce and strict-order mode.

## Interface
Parameters:
- `WIDTH`, 16, width of watched field and checkpoint values
- `DEPTH`, 8, max checkpoints; power of two, ≥2
- `TMO_W`, 18, timeout counter width
- `STABLE`, 2, consecutive matching cycles required per checkpoint (≥1)
- `STRICT`, 0, 1 = any stable value other than expected or last-matched is a failure

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  system clock; all state updates on rising edge
- `resetb`  in  1  synchronous active-low reset
- `cfg_we`  in  1  write checkpoint `cfg_addr` with `cfg_data`
- `cfg_addr`  in  log2(DEPTH)  checkpoint index
- `cfg_data`  in  WIDTH  checkpoint value
- `cfg_count`  in  log2(DEPTH)+1  number of checkpoints used; sampled on `start`
- `tmo_limit`  in  TMO_W  per-stage timeout in cycles; sampled on `start`
- `start`  in  1  single-cycle pulse; arms the sequence
- `watch`  in  WIDTH  observed field
- `busy`  out  1  sequence armed
- `pass`  out  1  sticky; all checkpoints matched
- `fail`  out  1  sticky; timeout or order violation
- `fail_code`  out  2  01 timeout, 10 strict-order violation, 00 none
- `stage`  out  log2(DEPTH)+1  index of the checkpoint currently expected or failed on
- `match_pulse`  out  1  one cycle per checkpoint matched

## Operation
- Reset (`resetb`=0 at an edge): state IDLE; all outputs 0; counters 0; `watch_q` and `last_q` 0. Checkpoint RAM contents are not reset.
- `watch` is registered into `watch_q` every cycle. All comparisons use `watch_q`.
- **IDLE / PASS / FAIL**
  - `cfg_we` writes the RAM.
  - `start` latches `cfg_count` and `tmo_limit`, clears `pass`/`fail`/`fail_code`/`stage`/counters, and enters ARMED.
  - If latched count = 0: go to PASS on the next edge.
  - `cfg_count` > DEPTH saturates to DEPTH.
- **ARMED** (`busy`=1)
  - `cfg_we` and `start` are ignored.
  - Each cycle `watch_q == ram[stage]`: `stab_cnt` +1; otherwise `stab_cnt` ← 0.
  - When `stab_cnt` reaches `STABLE`:
    - `match_pulse`=1 for one cycle.
    - `last_q` ← expected value.
    - `stage` +1; `stab_cnt` ← 0; timeout counter ← 0.
    - If new `stage` == count: go to PASS.
  - The timeout counter increments every ARMED cycle without a match. At `tmo_limit`: go to FAIL, `fail_code`=01.
  - `tmo_limit`=0 disables the timeout.
  - STRICT=1 only: `watch_q` unchanged for `STABLE` cycles, and the value equals neither `ram[stage]` nor `last_q` → FAIL, `fail_code`=10. Before the first match `last_q` is the value sampled at `start`.
- **Precedence in the same cycle:** match > timeout > strict violation.
- **Duplicate consecutive checkpoints** (`ram[i]==ram[i+1]`): the second needs a fresh `STABLE` run after the first match (`stab_cnt` cleared).
- PASS/FAIL are terminal until the next `start` or reset. `stage` holds its final value: = count on pass, the failing index on fail.

## Timing
- `watch` valid before edge k → `watch_q` at k → with a continuous match, `match_pulse` and the `stage` increment appear after edge k+`STABLE`.
- On the final checkpoint, `pass` and `busy`=0 take effect at the same edge as `match_pulse`.
- `start` at edge s → `busy`=1 after s. The timeout counter starts at 0 at s+1. `fail` rises after edge s+`tmo_limit` if nothing matches.
- Reset mid-sequence: everything is cleared at that edge and the next `start` is required.
- Timeout arithmetic is unsigned; the counter saturates and never wraps.

## Test plan
- **Basic pass.** Program 0xAB40, 0xAB41, 0xAB51, count=3, STABLE=2, tmo=1000. Drive each value for 5 cycles. Required: 3 `match_pulse`, each 2 edges after `watch_q` changes; `pass`=1; `stage`=3; `fail`=0.
- **Timeout.** Same config; drive 0xAB40 then hold 0x0000. Required: `fail`=1, `fail_code`=01, `stage`=1, exactly 1000 cycles after the first match.
- **Debounce.** Glitch 0xAB40 for 1 cycle with STABLE=2. Required: no `match_pulse`. A 2-cycle hold then matches.
- **Strict order.** STRICT=1; drive 0xAB40 then a stable 0xAB51. Required: `fail_code`=10, `stage`=1. Same stimulus with STRICT=0 gives no fail until timeout.
- **Config lockout and restart.** `cfg_we`/`start` while `busy` are ignored (RAM readback via a later sequence unchanged). `start` after PASS clears `pass` and re-arms. count=0 gives `pass` one edge after `start`.
- **Reset mid-operation.** `resetb`=0 for 1 cycle after the second match. Required: all outputs 0 on the next cycle; a new `start` runs the full sequence again.
